// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   - default widths (BIN_W_DEF, BCD_DIGITS_DEF)
//   - FSM state encoding (IDLE / SHIFT)
//   - add-3 threshold and the per-digit adjust function
package bin_to_bcd_seq_pkg;

  localparam int BIN_W_DEF      = 16;
  localparam int BCD_DIGITS_DEF = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // A digit of 5..9 becomes 8..12 so the following left shift carries
  // into the next decade. Max result 12 still fits in one nibble.
  function automatic logic [3:0] digit_adj(input logic [3:0] d);
    return (d >= ADD3_THRESH) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit double-dabble correction.
// Ports:
//   digit_in  - BCD scratch nibble before the shift
//   digit_out - digit_in + 3 when digit_in >= 5, otherwise digit_in
module bcd_digit_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = digit_adj(digit_in);

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// A start pulse captures bin_code; BIN_W clocks later bcd_code is updated
// and done pulses for one cycle. bcd_code holds between conversions.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   start    - single-cycle request, accepted only while idle
//   bin_code - binary value, sampled on the edge that accepts start
//   busy     - high while a conversion is running
//   done     - one-cycle pulse after bcd_code has been updated
//   bcd_code - packed BCD, most significant digit in the MSBs
// BCD_DIGITS must satisfy 10^BCD_DIGITS > 2^BIN_W - 1 so no significant
// bit is ever shifted out of the scratch register.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W      = BIN_W_DEF,
  parameter int BCD_DIGITS = BCD_DIGITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_code,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd_code
);

  localparam int SCR_W = 4 * BCD_DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t             state;
  state_t             state_nxt;
  logic [BIN_W-1:0]   bin_sr;
  logic [SCR_W-1:0]   scratch;
  logic [CNT_W-1:0]   cnt;
  logic               done_q;
  logic [SCR_W-1:0]   bcd_q;

  logic [SCR_W-1:0]   scr_adj;
  logic [SCR_W-1:0]   scr_shift;
  logic [BIN_W-1:0]   bin_shift;

  logic               do_load;
  logic               do_step;
  logic               do_finish;

  // Per-digit add-3 on the pre-shift scratch value
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (scratch[4*g +: 4]),
      .digit_out (scr_adj[4*g +: 4])
    );
  end

  // {scratch, binary} shifted left as one register; the scratch MSB falls off
  assign scr_shift = (scr_adj << 1) | SCR_W'(bin_sr[BIN_W-1]);
  assign bin_shift = bin_sr << 1;

  // Next-state and control strobes
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_step   = 1'b0;
    do_finish = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          do_load   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        do_step = 1'b1;
        if (cnt == CNT_LAST) begin
          do_finish = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: capture, shift, and result load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr  <= '0;
      scratch <= '0;
      cnt     <= '0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      done_q <= do_finish;
      if (do_load) begin
        bin_sr  <= bin_code;
        scratch <= '0;
        cnt     <= '0;
      end else if (do_step) begin
        bin_sr  <= bin_shift;
        scratch <= scr_shift;
        cnt     <= do_finish ? '0 : (cnt + CNT_W'(1));
      end
      // Only the completion edge touches the visible result
      if (do_finish) begin
        bcd_q <= scr_shift;
      end
    end
  end

  assign busy     = (state == SHIFT);
  assign done     = done_q;
  assign bcd_code = bcd_q;

endmodule
